alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_core.sv | 23 ++
 rtl/alu_share_arbiter.sv | 79 +++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state type and default widths for the shared ALU
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW = 3;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: stateless ALU; opcodes above OP_SLT are unsupported and flag err
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW = ALU_OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    always_comb begin
        err = op > OPW'(OP_SLT);
        result = op == OPW'(OP_AND) ? a & b :
                 op == OPW'(OP_OR)  ? a | b :
                 op == OPW'(OP_XOR) ? a ^ b :
                 op == OPW'(OP_ADD) ? a + b :
                 op == OPW'(OP_SUB) ? a - b :
                 op == OPW'(OP_SLT) ? WIDTH'($signed(a) < $signed(b)) : '0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one ALU through a round-robin IDLE/EXEC/RESP FSM
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW = ALU_OPW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*OPW-1:0]   req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_id,
    output logic               resp_err
);
    state_t state, state_nx;
    logic prio, grant_id, fire, lat_id, core_err;
    logic [OPW-1:0] lat_op;
    logic [WIDTH-1:0] lat_a, lat_b, core_res;

    // prio only matters when both requesters contend
    assign grant_id = &req_valid ? prio : req_valid[1];
    assign fire = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (fire ? EXEC : IDLE) :
                   state == EXEC ? RESP :
                   (state == RESP && !resp_ready) ? RESP : IDLE;
    end

    always_comb begin
        req_ready = (state == IDLE && !rst && |req_valid) ? 2'b01 << grant_id : 2'b00;
        resp_valid = state == RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
            lat_op <= '0;
            lat_a <= '0;
            lat_b <= '0;
            lat_id <= 1'b0;
            resp_data <= '0;
            resp_id <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (fire) begin
                lat_op <= grant_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
                lat_a <= grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                lat_b <= grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                lat_id <= grant_id;
                prio <= ~grant_id;
            end
            if (state == EXEC) begin
                resp_data <= core_res;
                resp_id <= lat_id;
                resp_err <= core_err;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_core (
        .a(lat_a),
        .b(lat_b),
        .op(lat_op),
        .result(core_res),
        .err(core_err)
    );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus against a transaction-level model checked every cycle
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid, req_ready;
    logic [5:0] req_op;
    logic [63:0] req_a, req_b;
    logic resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_data;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, a + b};
            3'd4: return {1'b0, a - b};
            3'd5: return {1'b0, 31'd0, $signed(a) < $signed(b)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // model: phase 0 idle, 1 computing, 2 holding a response
    int m_phase = 0;
    logic m_prio = 1'b0, m_pid = 1'b0, m_id = 1'b0, m_err = 1'b0;
    logic [32:0] m_pend = '0;
    logic [31:0] m_data = '0;
    int grant_log[$];
    logic [31:0] resp_log[$];

    function automatic logic winner();
        return (req_valid == 2'b11) ? m_prio : req_valid[1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_prio = 0; m_data = 0; m_id = 0; m_err = 0;
        end else if (m_phase == 0) begin
            if (|req_valid) begin
                m_pid = winner();
                m_pend = m_pid ? ref_alu(req_op[5:3], req_a[63:32], req_b[63:32])
                               : ref_alu(req_op[2:0], req_a[31:0], req_b[31:0]);
                m_prio = !m_pid;
                grant_log.push_back(int'(m_pid));
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            {m_err, m_data} = m_pend;
            m_id = m_pid;
            m_phase = 2;
        end else if (resp_ready) begin
            resp_log.push_back(m_data);
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        exp_rdy = (rst || m_phase != 0 || req_valid == 2'b00) ? 2'b00 : (winner() ? 2'b10 : 2'b01);
        chk("req_ready", req_ready, exp_rdy);
        chk("resp_valid", resp_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_id", resp_id, m_id);
            chk("resp_err", resp_err, m_err);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b;
        end else begin
            req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b;
        end
    endtask

    task automatic do_op(input string nm, input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic ee);
        bit found = 0;
        set_req(i, op, a, b);
        req_valid = (i == 0) ? 2'b01 : 2'b10;
        step(1);
        req_valid = 2'b00;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (resp_valid) found = 1;
        end
        chk({nm, "_resp_seen"}, found, 1);
        if (found) begin
            chk({nm, "_data"}, resp_data, ed);
            chk({nm, "_err"}, resp_err, ee);
            chk({nm, "_id"}, resp_id, i[0]);
        end
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int gb, rb;
        rst = 1; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1;
        step(2);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);

        // single request and latency
        @(posedge clk); #1;
        rst = 0;
        set_req(0, 3'b000, 32'hF0F0_FFFF, 32'h0FF0_00FF);
        req_valid = 2'b01;
        step(1);
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_exec_no_valid", resp_valid, 0);
        @(negedge clk);
        chk("t1_valid", resp_valid, 1);
        chk("t1_data", resp_data, 32'h00F0_00FF);
        chk("t1_id", resp_id, 0);
        chk("t1_err", resp_err, 0);
        step(1);

        // contention after reset
        rst = 1;
        step(1);
        rst = 0;
        gb = grant_log.size(); rb = resp_log.size();
        set_req(0, 3'b011, 32'hFFFF_FFFF, 32'h1);
        set_req(1, 3'b100, 32'd5, 32'd7);
        req_valid = 2'b11;
        step(12);
        req_valid = 2'b00;
        step(3);
        chk("cont_grants", grant_log.size() - gb, 4);
        chk("cont_resps", resp_log.size() - rb, 4);
        if (grant_log.size() - gb >= 4 && resp_log.size() - rb >= 4) begin
            chk("cont_g0", grant_log[gb], 0);
            chk("cont_g1", grant_log[gb+1], 1);
            chk("cont_g2", grant_log[gb+2], 0);
            chk("cont_g3", grant_log[gb+3], 1);
            chk("cont_r0", resp_log[rb], 32'h0000_0000);
            chk("cont_r1", resp_log[rb+1], 32'hFFFF_FFFE);
            chk("cont_r3", resp_log[rb+3], 32'hFFFF_FFFE);
        end

        // backpressure in RESP with requester 1 waiting
        resp_ready = 0;
        set_req(0, 3'b001, 32'h1234, 32'h8000);
        set_req(1, 3'b010, 32'hFF, 32'h0F);
        req_valid = 2'b01;
        step(1);
        req_valid = 2'b10;
        step(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, 32'h9234);
            chk("bp_id", resp_id, 0);
            chk("bp_ready", req_ready, 2'b00);
        end
        resp_ready = 1;
        rb = resp_log.size();
        step(1);
        @(negedge clk);
        chk("bp_one_handshake", resp_log.size() - rb, 1);
        chk("bp_idle_grant", req_ready, 2'b10);
        chk("bp_idle_valid", resp_valid, 0);
        step(1);
        req_valid = 2'b00;
        step(3);
        chk("bp_req1_result", resp_log[resp_log.size()-1], 32'hF0);

        // opcode edge cases
        do_op("op111", 0, 3'b111, 32'd5, 32'd3, 32'd0, 1'b1);
        do_op("op110", 1, 3'b110, 32'd5, 32'd3, 32'd0, 1'b1);
        do_op("slt_neg", 1, 3'b101, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
        do_op("slt_pos", 0, 3'b101, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
        do_op("add_wrap", 1, 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
        do_op("xor", 0, 3'b010, 32'hA5A5, 32'hFFFF, 32'h5A5A, 1'b0);

        // reset during EXEC abandons the op and restores priority to requester 0
        set_req(0, 3'b011, 32'd10, 32'd20);
        req_valid = 2'b01;
        step(1);
        req_valid = 2'b00;
        rst = 1;
        rb = resp_log.size();
        step(1);
        rst = 0;
        @(negedge clk);
        chk("rst_mid_data", resp_data, 0);
        chk("rst_mid_valid", resp_valid, 0);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_resp", resp_log.size() - rb, 0);
        set_req(1, 3'b001, 32'd1, 32'd2);
        req_valid = 2'b11;
        gb = grant_log.size();
        step(1);
        req_valid = 2'b00;
        chk("rst_mid_winner", grant_log.size() > gb ? grant_log[gb] : -1, 0);
        step(3);

        // withdrawal of requester 1 and operand change after acceptance
        set_req(0, 3'b011, 32'd100, 32'd23);
        req_valid = 2'b01;
        gb = grant_log.size();
        step(1);
        set_req(0, 3'b100, 32'd999, 32'd1);
        req_valid = 2'b10;
        step(1);
        req_valid = 2'b00;
        @(negedge clk);
        chk("wd_valid", resp_valid, 1);
        chk("wd_data", resp_data, 32'd123);
        chk("wd_id", resp_id, 0);
        step(4);
        chk("wd_one_grant", grant_log.size() - gb, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
